// File: rtl/sub_inst_resp_collector_if.sv
// rtl/sub_inst_resp_collector_if.sv - child/upstream response channel bundle for the collector
// slave: collector side; master: the children plus upstream consumer.
interface sub_inst_resp_collector_if #(
   parameter int N_CHILD = 5,
   parameter int DATA_W  = 16
);
   logic [N_CHILD-1:0]        in_valid;
   logic [N_CHILD*DATA_W-1:0] in_data;
   logic [N_CHILD-1:0]        in_ready;
   logic                      out_valid;
   logic [DATA_W-1:0]         out_data;
   logic [2:0]                out_src;
   logic                      out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_src
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_src
   );
endinterface

// File: rtl/sub_inst_resp_collector.sv
// rtl/sub_inst_resp_collector.sv - round-robin merge of child responses into one registered slot
// Grants are combinational against the slot-free condition; the slot refills in the cycle it drains.
module sub_inst_resp_collector #(
   parameter int N_CHILD = 5,
   parameter int DATA_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   sub_inst_resp_collector_if.slave  bus,
   output logic [15:0]               grant_cnt
);
   localparam logic [3:0] NC = 4'(N_CHILD);

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic [2:0]        out_src_q,   out_src_d;
   logic [2:0]        rr_ptr_q,    rr_ptr_d;
   logic [15:0]       grant_cnt_q, grant_cnt_d;

   logic       found;
   logic [2:0] gnt_idx;
   logic [3:0] cand;
   logic       slot_free;
   logic       grant;

   // First valid child at or after rr_ptr, wrapping modulo N_CHILD.
   always_comb begin
      found   = 1'b0;
      gnt_idx = 3'd0;
      cand    = 4'd0;
      for (int k = 0; k < N_CHILD; k++) begin
         cand = {1'b0, rr_ptr_q} + 4'(k);
         if (cand >= NC) begin
            cand = cand - NC;
         end
         if (!found && bus.in_valid[cand[2:0]]) begin
            found   = 1'b1;
            gnt_idx = cand[2:0];
         end
      end
   end

   assign slot_free = !out_valid_q || bus.out_ready;
   assign grant     = rst_n && slot_free && found;

   always_comb begin
      bus.in_ready = '0;
      for (int i = 0; i < N_CHILD; i++) begin
         bus.in_ready[i] = grant && (gnt_idx == 3'(i));
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      rr_ptr_d    = rr_ptr_q;
      grant_cnt_d = grant_cnt_q;
      if (grant) begin
         out_valid_d = 1'b1;
         out_data_d  = bus.in_data[gnt_idx*DATA_W +: DATA_W];
         out_src_d   = gnt_idx;
         rr_ptr_d    = (gnt_idx == 3'(N_CHILD - 1)) ? 3'd0 : gnt_idx + 3'd1;
         grant_cnt_d = grant_cnt_q + 16'd1;
      end else if (out_valid_q && bus.out_ready) begin
         // Drained with nothing to refill: payload and source keep their last values.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= 3'd0;
         rr_ptr_q    <= 3'd0;
         grant_cnt_q <= 16'd0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_cnt_q <= grant_cnt_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign grant_cnt     = grant_cnt_q;
endmodule

// File: tb/tb_sub_inst_resp_collector.sv
// tb/tb_sub_inst_resp_collector.sv - randomized and directed checks of the response collector
module tb_sub_inst_resp_collector;
   localparam int N  = 5;
   localparam int DW = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] grant_cnt;

   sub_inst_resp_collector_if #(.N_CHILD(N), .DATA_W(DW)) intf();

   sub_inst_resp_collector #(.N_CHILD(N), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (intf.slave),
      .grant_cnt (grant_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   bit          m_valid;
   logic [DW-1:0] m_data;
   int          m_src;
   int          m_ptr;
   logic [15:0] m_cnt;
   logic [DW-1:0] cdata [N];
   bit          rnd_mode;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_data();
      for (int i = 0; i < N; i++) intf.in_data[i*DW +: DW] = cdata[i];
   endtask

   task automatic model_clear();
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_ptr   = 0;
      m_cnt   = 16'd0;
   endtask

   function automatic int model_pick();
      int idx;
      if (m_valid && !intf.out_ready) return -1;
      for (int k = 0; k < N; k++) begin
         idx = (m_ptr + k) % N;
         if (intf.in_valid[idx]) return idx;
      end
      return -1;
   endfunction

   // Called at posedge+1; returns at the next posedge+1 with the model advanced.
   task automatic step();
      int g;
      logic [N-1:0] er;
      drive_data();
      #2;
      g  = model_pick();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      expect_eq("in_ready",  32'(intf.in_ready), 32'(er));
      expect_eq("out_valid", 32'(intf.out_valid), 32'(m_valid));
      expect_eq("out_data",  32'(intf.out_data), 32'(m_data));
      expect_eq("out_src",   32'(intf.out_src), 32'(m_src));
      expect_eq("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
      @(posedge clk);
      if (g >= 0) begin
         m_valid = 1'b1;
         m_data  = cdata[g];
         m_src   = g;
         m_ptr   = (g + 1) % N;
         m_cnt   = m_cnt + 16'd1;
      end else if (m_valid && intf.out_ready) begin
         m_valid = 1'b0;
      end
      #1;
      if (rnd_mode) begin
         if (g >= 0) begin
            if ($urandom_range(1, 0) == 1) intf.in_valid[g] = 1'b0;
            cdata[g] = DW'($urandom);
         end
         for (int i = 0; i < N; i++) begin
            if (!intf.in_valid[i] && $urandom_range(3, 0) == 0) begin
               intf.in_valid[i] = 1'b1;
               cdata[i] = DW'($urandom);
            end
         end
         intf.out_ready = ($urandom_range(9, 0) < 7);
      end
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      intf.in_valid  = '1;
      intf.out_ready = 1'b1;
      for (int i = 0; i < N; i++) cdata[i] = '0;
      drive_data();
      #2;
      expect_eq("rst_in_ready",  32'(intf.in_ready), 32'd0);
      expect_eq("rst_out_valid", 32'(intf.out_valid), 32'd0);
      expect_eq("rst_out_data",  32'(intf.out_data), 32'd0);
      expect_eq("rst_out_src",   32'(intf.out_src), 32'd0);
      expect_eq("rst_grant_cnt", 32'(grant_cnt), 32'd0);
      intf.in_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
   endtask

   initial begin
      int seq_exp [7] = '{0, 1, 2, 3, 4, 0, 1};
      rst_n          = 1'b0;
      rnd_mode       = 1'b0;
      intf.in_valid  = '0;
      intf.in_data   = '0;
      intf.out_ready = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      do_reset();

      // single child, one-cycle latency
      intf.in_valid  = 5'b00100;
      cdata[2]       = 16'h1234;
      intf.out_ready = 1'b1;
      step();
      expect_eq("single_valid", 32'(intf.out_valid), 32'd1);
      expect_eq("single_data",  32'(intf.out_data), 32'h1234);
      expect_eq("single_src",   32'(intf.out_src), 32'd2);
      expect_eq("single_cnt",   32'(grant_cnt), 32'd1);
      intf.in_valid = '0;
      step();
      expect_eq("drain_valid", 32'(intf.out_valid), 32'd0);
      expect_eq("drain_hold",  32'(intf.out_data), 32'h1234);

      // all valid, full throughput round robin
      do_reset();
      for (int i = 0; i < N; i++) cdata[i] = DW'(16'hA000 + i);
      intf.in_valid  = '1;
      intf.out_ready = 1'b1;
      for (int s = 0; s < 7; s++) begin
         step();
         expect_eq("rr_valid", 32'(intf.out_valid), 32'd1);
         expect_eq("rr_src",   32'(intf.out_src), 32'(seq_exp[s]));
      end

      // backpressure hold then same-cycle refill
      do_reset();
      intf.in_valid  = 5'b01000;
      cdata[3]       = 16'hBEEF;
      intf.out_ready = 1'b0;
      step();
      intf.in_valid = 5'b10111;
      for (int i = 0; i < N; i++) if (i != 3) cdata[i] = DW'(16'h5000 + i);
      for (int s = 0; s < 4; s++) begin
         step();
         expect_eq("bp_data", 32'(intf.out_data), 32'hBEEF);
         expect_eq("bp_src",  32'(intf.out_src), 32'd3);
      end
      intf.out_ready = 1'b1;
      step();
      expect_eq("bp_refill_valid", 32'(intf.out_valid), 32'd1);
      expect_eq("bp_refill_src",   32'(intf.out_src), 32'd4);

      // wrap and skip from rr_ptr=4
      do_reset();
      intf.out_ready = 1'b1;
      intf.in_valid  = 5'b01000;
      step();
      intf.in_valid = 5'b00011;
      step();
      expect_eq("wrap_src0", 32'(intf.out_src), 32'd0);
      step();
      expect_eq("wrap_src1", 32'(intf.out_src), 32'd1);
      intf.in_valid = 5'b11111;
      step();
      expect_eq("wrap_src2", 32'(intf.out_src), 32'd2);

      // asynchronous reset while the slot is full
      intf.out_ready = 1'b0;
      intf.in_valid  = 5'b10110;
      #2;
      expect_eq("pre_rst_valid", 32'(intf.out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      expect_eq("arst_valid", 32'(intf.out_valid), 32'd0);
      expect_eq("arst_ready", 32'(intf.in_ready), 32'd0);
      expect_eq("arst_cnt",   32'(grant_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
      step();
      expect_eq("post_rst_src", 32'(intf.out_src), 32'd1);

      // randomized traffic against the model
      do_reset();
      rnd_mode = 1'b1;
      repeat (3000) step();
      rnd_mode = 1'b0;

      // grant counter wrap
      do_reset();
      intf.in_valid  = '1;
      intf.out_ready = 1'b1;
      repeat (65536) step();
      expect_eq("cnt_wrap", 32'(grant_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
